// File: rtl/mdio_phy_responder_if.sv
// MDIO pad and write-notify bundle between the management master and the PHY responder.
interface mdio_phy_responder_if;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  modport master (
    output mdc, mdio_i,
    input  mdio_o, mdio_oe, wr_valid, wr_addr, wr_data
  );

  modport slave (
    input  mdc, mdio_i,
    output mdio_o, mdio_oe, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder with a 32x16 register file.
// Optional MDIO_SOFT_RESET_EN: writing r0 bit15 reloads all register defaults.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'h01,
  parameter int          PRE_LEN  = 32,
  parameter logic [15:0] PHY_ID1  = 16'h001C,
  parameter logic [15:0] PHY_ID2  = 16'hC915,
  parameter logic [15:0] BMSR_RST = 16'h796D
) (
  input  logic clk,
  input  logic rst,
  mdio_phy_responder_if.slave bus
);

  localparam int PW = $clog2(PRE_LEN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ST    = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_PHYAD = 3'd3;
  localparam logic [2:0] S_REGAD = 3'd4;
  localparam logic [2:0] S_TA    = 3'd5;
  localparam logic [2:0] S_RDATA = 3'd6;
  localparam logic [2:0] S_WDATA = 3'd7;

  function automatic logic [15:0] reg_default(input logic [4:0] a);
    logic [15:0] v;
    v = 16'h0000;
    unique case (a)
      5'd0:    v = 16'h1140;
      5'd1:    v = BMSR_RST;
      5'd2:    v = PHY_ID1;
      5'd3:    v = PHY_ID2;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  logic [1:0]  mdc_sync;
  logic [1:0]  mdio_sync;
  logic        mdc_q;
  logic        rise;
  logic        fall;
  logic        bit_in;

  logic [2:0]  state;
  logic [PW-1:0] pre_cnt;
  logic [4:0]  bit_cnt;
  logic        rd_op;
  logic        match;
  logic [3:0]  phyad;
  logic [4:0]  regad;
  logic [15:0] shreg;
  logic        oe_q;
  logic        o_q;
  logic        commit;

  logic [15:0] regs [32];
  logic        wv_q;
  logic [4:0]  wa_q;
  logic [15:0] wd_q;
  logic        ro_addr;

  assign rise    = mdc_sync[1] & ~mdc_q;
  assign fall    = ~mdc_sync[1] & mdc_q;
  assign bit_in  = mdio_sync[1];
  assign ro_addr = (regad == 5'd1) || (regad == 5'd2) || (regad == 5'd3);

  assign bus.mdio_o   = o_q;
  assign bus.mdio_oe  = oe_q;
  assign bus.wr_valid = wv_q;
  assign bus.wr_addr  = wa_q;
  assign bus.wr_data  = wd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_sync  <= 2'b00;
      mdio_sync <= 2'b11;
      mdc_q     <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[0], bus.mdc};
      mdio_sync <= {mdio_sync[0], bus.mdio_i};
      mdc_q     <= mdc_sync[1];
    end
  end

  // Frame decoder: bits sampled on MDC rise, read data launched on MDC fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pre_cnt <= '0;
      bit_cnt <= 5'd0;
      rd_op   <= 1'b0;
      match   <= 1'b0;
      phyad   <= 4'd0;
      regad   <= 5'd0;
      shreg   <= 16'h0000;
      oe_q    <= 1'b0;
      o_q     <= 1'b1;
      commit  <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (rise) begin
        unique case (state)
          S_IDLE: begin
            if (bit_in) begin
              if (pre_cnt != PW'(PRE_LEN))
                pre_cnt <= pre_cnt + 1'b1;
            end else if (pre_cnt == PW'(PRE_LEN)) begin
              state   <= S_ST;
              pre_cnt <= '0;
            end else begin
              pre_cnt <= '0;
            end
          end
          S_ST: begin
            state   <= bit_in ? S_OP : S_IDLE;
            bit_cnt <= 5'd0;
          end
          S_OP: begin
            if (bit_cnt == 5'd0) begin
              rd_op   <= bit_in;
              bit_cnt <= 5'd1;
            end else begin
              bit_cnt <= 5'd0;
              state   <= (rd_op != bit_in) ? S_PHYAD : S_IDLE;
            end
          end
          S_PHYAD: begin
            phyad <= {phyad[2:0], bit_in};
            if (bit_cnt == 5'd4) begin
              match   <= ({phyad, bit_in} == PHY_ADDR);
              bit_cnt <= 5'd0;
              state   <= S_REGAD;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_REGAD: begin
            regad <= {regad[3:0], bit_in};
            if (bit_cnt == 5'd4) begin
              bit_cnt <= 5'd0;
              state   <= S_TA;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_TA: begin
            if (bit_cnt == 5'd0) begin
              bit_cnt <= 5'd1;
            end else begin
              bit_cnt <= 5'd0;
              shreg   <= rd_op ? regs[regad] : 16'h0000;
              state   <= rd_op ? S_RDATA : S_WDATA;
            end
          end
          S_WDATA: begin
            shreg <= {shreg[14:0], bit_in};
            if (bit_cnt == 5'd15) begin
              commit  <= match;
              bit_cnt <= 5'd0;
              state   <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: ;
        endcase
      end else if (fall) begin
        if (state == S_TA && bit_cnt == 5'd1 && rd_op && match) begin
          oe_q <= 1'b1;
          o_q  <= 1'b0;
        end else if (state == S_RDATA) begin
          if (bit_cnt == 5'd16) begin
            oe_q    <= 1'b0;
            o_q     <= 1'b1;
            bit_cnt <= 5'd0;
            state   <= S_IDLE;
          end else begin
            o_q     <= shreg[15] | ~match;
            shreg   <= {shreg[14:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
      end
    end
  end

`ifdef MDIO_SOFT_RESET_EN
  logic soft_pend;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= reg_default(5'(i));
      wv_q <= 1'b0;
      wa_q <= 5'd0;
      wd_q <= 16'h0000;
`ifdef MDIO_SOFT_RESET_EN
      soft_pend <= 1'b0;
`endif
    end else begin
      wv_q <= 1'b0;
      if (commit && !ro_addr) begin
        regs[regad] <= shreg;
        wv_q        <= 1'b1;
        wa_q        <= regad;
        wd_q        <= shreg;
      end
`ifdef MDIO_SOFT_RESET_EN
      soft_pend <= commit && (regad == 5'd0) && shreg[15];
      if (soft_pend)
        for (int i = 0; i < 32; i++)
          regs[i] <= reg_default(5'(i));
`endif
    end
  end

endmodule
